// File: rtl/hydra_pkg.sv
// Shared types for the strand memory read path.
// Config record layout and scheduler state encoding.
package hydra_pkg;

    localparam int STRAND_PARAM_WIDTH = 16;
    localparam int MEM_ADDR_WIDTH     = 24;

    typedef struct packed {
        logic [STRAND_PARAM_WIDTH-1:0] offset;
        logic [STRAND_PARAM_WIDTH-1:0] length;
        logic                          enable;
    } strand_cfg_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        REQ,
        DONE
    } sched_state_t;

endpackage

// File: rtl/address_generator.sv
// Registered strand address: base offset plus pixel index.
module address_generator
    import hydra_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [STRAND_PARAM_WIDTH-1:0] strand_offset_i,
    input  logic [STRAND_PARAM_WIDTH-1:0] strand_idx_i,
    output logic [MEM_ADDR_WIDTH-1:0]     addr_o
);

    logic [MEM_ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= MEM_ADDR_WIDTH'(strand_offset_i)
                    + MEM_ADDR_WIDTH'(strand_idx_i);
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/strand_config_bank.sv
// Double-buffered per-strand configuration: host writes pending,
// a swap strobe snapshots pending into active for the frame.
module strand_config_bank
    import hydra_pkg::*;
#(
    parameter int NUM_STRANDS = 8,
    parameter int SW          = $clog2(NUM_STRANDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [SW-1:0] wr_strand_i,
    input  strand_cfg_t wr_cfg_i,
    input  logic        swap_i,
    input  logic [SW-1:0] rd_strand_i,
    output strand_cfg_t rd_cfg_o
);

    strand_cfg_t pend_q [NUM_STRANDS];
    strand_cfg_t act_q  [NUM_STRANDS];

    // A write coincident with swap lands in pending only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STRANDS; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            if (swap_i) begin
                act_q <= pend_q;
            end
            if (we_i) begin
                pend_q[wr_strand_i] <= wr_cfg_i;
            end
        end
    end

    assign rd_cfg_o = act_q[rd_strand_i];

endmodule

// File: rtl/strand_scheduler.sv
// Frame sequencer: walks enabled strands and pixels, issuing one
// memory read per pixel over a valid/ready handshake.
module strand_scheduler
    import hydra_pkg::*;
#(
    parameter int NUM_STRANDS = 8,
    parameter int SW          = $clog2(NUM_STRANDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [SW-1:0]                 cfg_strand,
    input  logic [STRAND_PARAM_WIDTH-1:0] cfg_offset,
    input  logic [STRAND_PARAM_WIDTH-1:0] cfg_length,
    input  logic                          cfg_enable,
    input  logic                          frame_start,
    output logic                          busy,
    output logic                          frame_done,
    output logic [STRAND_PARAM_WIDTH-1:0] ag_strand_offset,
    output logic [STRAND_PARAM_WIDTH-1:0] ag_strand_idx,
    output logic [STRAND_PARAM_WIDTH-1:0] ag_strand_length,
    input  logic [MEM_ADDR_WIDTH-1:0]     ag_addr,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [MEM_ADDR_WIDTH-1:0]     rd_addr,
    output logic [SW-1:0]                 rd_strand,
    output logic [STRAND_PARAM_WIDTH-1:0] rd_idx,
    output logic                          rd_last
);

    localparam logic [SW-1:0] LAST_S = SW'(NUM_STRANDS - 1);
    localparam logic [STRAND_PARAM_WIDTH-1:0] ONE = STRAND_PARAM_WIDTH'(1);

    sched_state_t                  state_q;
    logic [SW-1:0]                 s_q;
    logic                          busy_q;
    logic                          frame_done_q;
    logic [STRAND_PARAM_WIDTH-1:0] ag_off_q;
    logic [STRAND_PARAM_WIDTH-1:0] ag_idx_q;
    logic [STRAND_PARAM_WIDTH-1:0] ag_len_q;
    logic                          rd_valid_q;
    logic [SW-1:0]                 rd_strand_q;
    logic [STRAND_PARAM_WIDTH-1:0] rd_idx_q;
    logic                          rd_last_q;

    strand_cfg_t wr_cfg;
    strand_cfg_t sel_cfg;
    logic        swap;

    assign wr_cfg = '{offset: cfg_offset, length: cfg_length, enable: cfg_enable};
    assign swap   = (state_q == IDLE) && frame_start;

    strand_config_bank #(
        .NUM_STRANDS (NUM_STRANDS),
        .SW          (SW)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .we_i        (cfg_we),
        .wr_strand_i (cfg_strand),
        .wr_cfg_i    (wr_cfg),
        .swap_i      (swap),
        .rd_strand_i (s_q),
        .rd_cfg_o    (sel_cfg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ag_off_q     <= '0;
            ag_idx_q     <= '0;
            ag_len_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_strand_q  <= '0;
            rd_idx_q     <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q <= SELECT;
                        s_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (sel_cfg.enable && sel_cfg.length != '0) begin
                        state_q  <= ISSUE;
                        ag_off_q <= sel_cfg.offset;
                        ag_len_q <= sel_cfg.length;
                        ag_idx_q <= '0;
                    end else if (s_q == LAST_S) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                // ag_addr for the current pixel is ready by REQ entry
                ISSUE: begin
                    state_q     <= REQ;
                    rd_valid_q  <= 1'b1;
                    rd_strand_q <= s_q;
                    rd_idx_q    <= ag_idx_q;
                    rd_last_q   <= (ag_idx_q == ag_len_q - ONE);
                end
                REQ: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (!rd_last_q) begin
                            state_q  <= ISSUE;
                            ag_idx_q <= ag_idx_q + ONE;
                        end else if (s_q == LAST_S) begin
                            state_q      <= DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= SELECT;
                            s_q     <= s_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign ag_strand_offset = ag_off_q;
    assign ag_strand_idx    = ag_idx_q;
    assign ag_strand_length = ag_len_q;
    assign rd_valid         = rd_valid_q;
    assign rd_addr          = rd_valid_q ? ag_addr : '0;
    assign rd_strand        = rd_strand_q;
    assign rd_idx           = rd_idx_q;
    assign rd_last          = rd_last_q;

endmodule

// File: tb/tb_strand_scheduler.sv
// Bench for strand_scheduler: directed frames plus randomized configs,
// stalls and config writes, checked against a frame-level model.
module tb_strand_scheduler;
    import hydra_pkg::*;

    localparam int NS = 8;
    localparam int SW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [SW-1:0] cfg_strand;
    logic [15:0] cfg_offset;
    logic [15:0] cfg_length;
    logic        cfg_enable;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic [15:0] ag_strand_offset;
    logic [15:0] ag_strand_idx;
    logic [15:0] ag_strand_length;
    logic [23:0] ag_addr;
    logic        rd_valid;
    logic        rd_ready;
    logic [23:0] rd_addr;
    logic [SW-1:0] rd_strand;
    logic [15:0] rd_idx;
    logic        rd_last;

    always #5 clk = ~clk;

    strand_scheduler #(.NUM_STRANDS(NS), .SW(SW)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_strand       (cfg_strand),
        .cfg_offset       (cfg_offset),
        .cfg_length       (cfg_length),
        .cfg_enable       (cfg_enable),
        .frame_start      (frame_start),
        .busy             (busy),
        .frame_done       (frame_done),
        .ag_strand_offset (ag_strand_offset),
        .ag_strand_idx    (ag_strand_idx),
        .ag_strand_length (ag_strand_length),
        .ag_addr          (ag_addr),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_addr          (rd_addr),
        .rd_strand        (rd_strand),
        .rd_idx           (rd_idx),
        .rd_last          (rd_last)
    );

    address_generator u_ag (
        .clk             (clk),
        .rst             (rst),
        .strand_offset_i (ag_strand_offset),
        .strand_idx_i    (ag_strand_idx),
        .addr_o          (ag_addr)
    );

    typedef struct {
        int s;
        int idx;
        int addr;
        int len;
        bit last;
    } req_t;

    int checks = 0;
    int failures = 0;

    int unsigned p_off [NS];
    int unsigned p_len [NS];
    bit          p_en  [NS];
    int unsigned a_off [NS];
    int unsigned a_len [NS];
    bit          a_en  [NS];
    req_t        expq [$];

    int wr_s, wr_off, wr_len;
    bit wr_en;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_write(input int s, input int off, input int len,
                               input bit en);
        cfg_we     = 1'b1;
        cfg_strand = SW'(s);
        cfg_offset = 16'(off);
        cfg_length = 16'(len);
        cfg_enable = en;
        p_off[s]   = off;
        p_len[s]   = len;
        p_en[s]    = en;
    endtask

    task automatic cfg_write(input int s, input int off, input int len,
                             input bit en);
        @(negedge clk);
        drive_write(s, off, len, en);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, frame_done, 0);
        check({pfx, "_valid"}, rd_valid, 0);
        check({pfx, "_addr"}, rd_addr, 0);
        check({pfx, "_idx"}, rd_idx, 0);
        check({pfx, "_strand"}, rd_strand, 0);
        check({pfx, "_last"}, rd_last, 0);
        check({pfx, "_ag_off"}, ag_strand_offset, 0);
        check({pfx, "_ag_idx"}, ag_strand_idx, 0);
        check({pfx, "_ag_len"}, ag_strand_length, 0);
    endtask

    // mw_cyc: -1 none, 0 write alongside frame_start, >0 write mid-frame
    task automatic run_frame(input int stall_pct, input int stall_idx,
                             input int mw_cyc);
        int e, cyc, stalls, total, first_k, stall_left;
        bit done, held, first_seen, stalled_once;
        logic [23:0] h_addr;
        logic [15:0] h_idx;
        logic [SW-1:0] h_strand;
        logic h_last;
        req_t r;

        @(negedge clk);
        frame_start = 1'b1;
        rd_ready = 1'b0;
        expq.delete();
        total = 0;
        first_k = -1;
        for (int s = 0; s < NS; s++) begin
            a_off[s] = p_off[s];
            a_len[s] = p_len[s];
            a_en[s]  = p_en[s];
            total += 1;
            if (a_en[s] && a_len[s] != 0) begin
                if (first_k < 0) first_k = s;
                total += 2 * a_len[s];
                for (int i = 0; i < int'(a_len[s]); i++) begin
                    r.s = s;
                    r.idx = i;
                    r.addr = a_off[s] + i;
                    r.len = a_len[s];
                    r.last = (i == int'(a_len[s]) - 1);
                    expq.push_back(r);
                end
            end
        end
        if (mw_cyc == 0) drive_write(wr_s, wr_off, wr_len, wr_en);
        @(posedge clk);
        e = 0;
        @(negedge clk);
        frame_start = 1'b0;
        cycles_loop_init: begin
            cyc = 0; stalls = 0; done = 0; held = 0;
            first_seen = 0; stall_left = 0; stalled_once = 0;
        end
        while (!done && cyc < 5000) begin
            cfg_we = 1'b0;
            if (mw_cyc > 0 && cyc == mw_cyc)
                drive_write(wr_s, wr_off, wr_len, wr_en);
            if (rd_valid && stall_idx >= 0 && int'(rd_idx) == stall_idx
                && !stalled_once) begin
                stall_left = 5;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
            end else begin
                rd_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            check("busy_in_frame", busy, 1);
            if (rd_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    check("first_valid_edge", e + 1, first_k + 3);
                end
                if (held) begin
                    check("hold_addr", rd_addr, h_addr);
                    check("hold_idx", rd_idx, h_idx);
                    check("hold_strand", rd_strand, h_strand);
                    check("hold_last", rd_last, h_last);
                end
                if (rd_ready) begin
                    held = 0;
                    if (expq.size() == 0) begin
                        check("extra_req", 1, 0);
                    end else begin
                        r = expq.pop_front();
                        check("req_strand", rd_strand, r.s);
                        check("req_idx", rd_idx, r.idx);
                        check("req_addr", rd_addr, r.addr);
                        check("req_last", rd_last, r.last);
                        check("ag_idx", ag_strand_idx, r.idx);
                        check("ag_len", ag_strand_length, r.len);
                    end
                end else begin
                    stalls++;
                    held = 1;
                    h_addr = rd_addr;
                    h_idx = rd_idx;
                    h_strand = rd_strand;
                    h_last = rd_last;
                end
            end
            if (frame_done) begin
                done = 1;
                check("done_edge", e + 1, total + stalls + 1);
                check("reqs_left", expq.size(), 0);
            end
            @(posedge clk);
            e++;
            @(negedge clk);
            cyc++;
        end
        cfg_we = 1'b0;
        if (!done) check("frame_timeout", 0, 1);
        check("done_pulse_len", frame_done, 0);
        check("busy_after", busy, 0);
        check("valid_after", rd_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_strand = '0;
        cfg_offset = '0;
        cfg_length = '0;
        cfg_enable = 1'b0;
        frame_start = 1'b0;
        rd_ready = 1'b0;
        for (int s = 0; s < NS; s++) begin
            p_off[s] = 0; p_len[s] = 0; p_en[s] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_quiet("reset");

        cfg_write(0, 320, 3, 1);
        run_frame(0, -1, -1);

        cfg_write(0, 0, 0, 0);
        cfg_write(2, 640, 2, 1);
        cfg_write(5, 100, 1, 1);
        run_frame(0, -1, -1);

        cfg_write(2, 0, 0, 0);
        cfg_write(5, 0, 0, 0);
        cfg_write(0, 320, 3, 1);
        run_frame(0, 1, -1);

        wr_s = 0; wr_off = 320; wr_len = 1; wr_en = 1;
        run_frame(0, -1, 4);
        run_frame(0, -1, -1);

        cfg_write(0, 320, 1, 0);
        cfg_write(3, 50, 0, 1);
        run_frame(0, -1, -1);

        cfg_write(7, 16'hFFFF, 2, 1);
        run_frame(0, -1, -1);

        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < NS; s++)
                cfg_write(s, $urandom_range(0, 65535), $urandom_range(0, 5),
                          1'($urandom_range(0, 1)));
            wr_s = $urandom_range(0, NS - 1);
            wr_off = $urandom_range(0, 65535);
            wr_len = $urandom_range(0, 5);
            wr_en = 1'($urandom_range(0, 1));
            run_frame(25, -1, $urandom_range(0, 10));
        end

        cfg_write(0, 320, 3, 1);
        cfg_write(4, 77, 2, 1);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rd_ready = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < NS; s++) begin
            p_off[s] = 0; p_len[s] = 0; p_en[s] = 0;
        end
        check_quiet("midreset");
        run_frame(0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
